// File: rtl/frame_pixel_streamer.sv
// Frame-buffer transmitter: holds one WIDTH x HEIGHT 8-bit frame and streams it in raster order.
// Optional running pixel checksum output when STREAM_CHECKSUM_EN is defined.
module frame_pixel_streamer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int GAP    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [13:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        go,
  input  logic        sink_done,
  output logic        start,
  output logic [7:0]  pixel_out,
  output logic        pixel_out_valid,
  output logic        busy,
  output logic        done
`ifdef STREAM_CHECKSUM_EN
  ,output logic [15:0] checksum
`endif
);
  localparam int          TOTAL    = WIDTH * HEIGHT;
  localparam int          AW       = $clog2(TOTAL);
  localparam logic [13:0] LAST     = 14'(TOTAL - 1);
  localparam logic [3:0]  GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, STREAM, HOLD, WAIT_DONE} state_t;
  state_t state, state_nx;

  logic [13:0] rd_addr, rd_addr_nx, ra;
  logic [3:0]  gap_cnt, gap_cnt_nx;
  logic [7:0]  rd_data, last_pix;
  logic        done_q;

  (* ram_style = "block" *) logic [7:0] mem [TOTAL];

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE && 32'(wr_addr) < TOTAL) mem[wr_addr[AW-1:0]] <= wr_data;
    rd_data <= mem[ra[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      gap_cnt  <= '0;
      last_pix <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_addr  <= rd_addr_nx;
      gap_cnt  <= gap_cnt_nx;
      last_pix <= pixel_out;
      done_q   <= (state == WAIT_DONE) && sink_done;
    end
  end

  // ra is the address presented to the BRAM this cycle, so data is ready one cycle later
  always_comb begin
    state_nx        = state;
    rd_addr_nx      = rd_addr;
    gap_cnt_nx      = gap_cnt;
    ra              = rd_addr;
    start           = 1'b0;
    pixel_out_valid = 1'b0;
    case (state)
      IDLE: if (go && !done_q) begin
        rd_addr_nx = '0;
        gap_cnt_nx = '0;
        state_nx   = START;
      end
      START: begin
        start    = 1'b1;
        ra       = '0;
        state_nx = STREAM;
      end
      STREAM: begin
        pixel_out_valid = 1'b1;
        if (rd_addr == LAST) state_nx = WAIT_DONE;
        else begin
          rd_addr_nx = rd_addr + 14'd1;
          ra         = rd_addr + 14'd1;
          gap_cnt_nx = '0;
          state_nx   = (GAP > 0) ? HOLD : STREAM;
        end
      end
      HOLD: begin
        if (gap_cnt == GAP_LAST) state_nx = STREAM;
        else gap_cnt_nx = gap_cnt + 4'd1;
      end
      WAIT_DONE: if (sink_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign pixel_out = pixel_out_valid ? rd_data : last_pix;
  assign busy      = (state != IDLE);
  assign done      = done_q;

`ifdef STREAM_CHECKSUM_EN
  logic [15:0] csum;
  always_ff @(posedge clk) begin
    if (rst || state == START) csum <= '0;
    else if (pixel_out_valid)  csum <= csum + {8'd0, pixel_out};
  end
  assign checksum = csum;
`endif
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Scoreboard bench: stimulus queues expected start/pixel/done events, a negedge monitor checks them.
module tb_frame_pixel_streamer;
  localparam int W = 16, H = 8, G = 2, TOT = W * H, P = G + 1;

  logic        clk = 0, rst = 1, wr_en = 0, go = 0, sink_done = 0;
  logic [13:0] wr_addr = 0;
  logic [7:0]  wr_data = 0;
  logic        start, pixel_out_valid, busy, done;
  logic [7:0]  pixel_out;
`ifdef STREAM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  frame_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .GAP(G)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .sink_done(sink_done), .start(start), .pixel_out(pixel_out),
    .pixel_out_valid(pixel_out_valid), .busy(busy), .done(done)
`ifdef STREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic [7:0] v; } pix_t;
  pix_t exp_pix[$];
  pix_t e;
  int   exp_start[$], exp_done[$];
  int   et;
  logic [7:0] img [TOT];
  int nvec = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pixel_out_valid) begin
      if (exp_pix.size() == 0) chk("unexpected_pixel", 32'(pixel_out_valid), 0);
      else begin
        e = exp_pix.pop_front();
        chk("pix_time", cyc, e.t);
        chk("pix_val", 32'(pixel_out), 32'(e.v));
      end
    end
    if (start) begin
      if (exp_start.size() == 0) chk("unexpected_start", 32'(start), 0);
      else begin et = exp_start.pop_front(); chk("start_time", cyc, et); end
    end
    if (done) begin
      if (exp_done.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin et = exp_done.pop_front(); chk("done_time", cyc, et); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1; wr_addr = 14'(a); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic start_frame(output int t);
    t = cyc;
    go = 1;
    exp_start.push_back(t + 1);
    for (int k = 0; k < TOT; k++) exp_pix.push_back('{t + 2 + k * P, img[k]});
    tick();
    go = 0;
    chk("busy_at_start", 32'(busy), 1);
  endtask

  task automatic finish_frame(input int t);
    int d;
    while (cyc < t + 2 + (TOT - 1) * P + 3) tick();
    chk("busy_wait_done", 32'(busy), 1);
    chk("valid_wait_done", 32'(pixel_out_valid), 0);
    chk("pix_queue_drained", exp_pix.size(), 0);
    sink_done = 1;
    d = cyc;
    exp_done.push_back(d + 1);
    tick();
    sink_done = 0;
    chk("busy_after_done", 32'(busy), 0);
    tick();
  endtask

`ifdef STREAM_CHECKSUM_EN
  task automatic chk_sum();
    logic [15:0] s = 0;
    for (int k = 0; k < TOT; k++) s += {8'd0, img[k]};
    chk("checksum", 32'(checksum), 32'(s));
  endtask
`endif

  initial begin
    int t;
    repeat (3) tick();
    chk("rst_start", 32'(start), 0);
    chk("rst_pixel", 32'(pixel_out), 0);
    chk("rst_valid", 32'(pixel_out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 0;
    tick();

    for (int a = 0; a < TOT; a++) begin
      img[a] = 8'((a * 3 + 5) % 256);
      wr(a, img[a]);
    end
    wr(TOT + 5, 8'hAA);

    // go, write and sink_done while streaming must all be ignored
    start_frame(t);
    while (cyc < t + 2 + 5 * P) tick();
    go = 1; wr_en = 1; wr_addr = 0; wr_data = 8'hFF; sink_done = 1;
    tick();
    go = 0; wr_en = 0; sink_done = 0;
    chk("done_ignored_in_stream", 32'(done), 0);
    finish_frame(t);
`ifdef STREAM_CHECKSUM_EN
    chk_sum();
`endif

    // reset during pixel 10, then restart from pixel 0 with buffer intact
    start_frame(t);
    while (cyc < t + 2 + 10 * P) tick();
    rst = 1;
    tick();
    exp_pix.delete();
    chk("mid_rst_valid", 32'(pixel_out_valid), 0);
    chk("mid_rst_pixel", 32'(pixel_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_start", 32'(start), 0);
    rst = 0;
    tick();
    sink_done = 1; tick(); sink_done = 0;
    repeat (3) tick();
    chk("no_done_after_rst", 32'(done), 0);
    start_frame(t);
    finish_frame(t);

    // a write immediately before go is visible in that frame
    img[0] = 8'h77;
    img[TOT-1] = 8'h01;
    wr(0, img[0]);
    wr_en = 1; wr_addr = 14'(TOT - 1); wr_data = img[TOT-1];
    start_frame(t);
    wr_en = 0;
    finish_frame(t);
`ifdef STREAM_CHECKSUM_EN
    chk_sum();
`endif

    repeat (4) tick();
    chk("start_queue_drained", exp_start.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
